// File: rtl/cnn_pkg.sv
// Shared types and sizing helpers for the CNN patch streaming blocks.
package cnn_pkg;

    localparam int DW_DEFAULT = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LAST,
        ST_EMIT,
        ST_DONE
    } ps_state_t;

    // Number of output positions along one axis of a padded, strided convolution.
    function automatic int conv_out_size(input int n, input int k, input int s, input int p);
        return (n + 2 * p - k) / s + 1;
    endfunction

    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/patch_addr_gen.sv
// Maps an output position (row, col) and a window offset (m, n) to an image
// read address, flagging offsets that fall into the zero-padding border.
module patch_addr_gen
    import cnn_pkg::*;
#(
    parameter int H  = 5,
    parameter int W  = 5,
    parameter int K  = 3,
    parameter int S  = 1,
    parameter int P  = 1,
    parameter int AW = clog2_min1(H * W),
    parameter int RW = clog2_min1(conv_out_size(H, K, S, P)),
    parameter int CW = clog2_min1(conv_out_size(W, K, S, P)),
    parameter int KW = clog2_min1(K)
) (
    input  logic [RW-1:0] row,
    input  logic [CW-1:0] col,
    input  logic [KW-1:0] m,
    input  logic [KW-1:0] n,
    output logic [AW-1:0] addr,
    output logic          in_bounds
);

    // Wide enough that row*S - P never wraps for any sane parameter set.
    localparam int XW = AW + clog2_min1(S + P + K) + 2;

    localparam logic signed [XW-1:0] S_X = XW'(S);
    localparam logic signed [XW-1:0] P_X = XW'(P);
    localparam logic signed [XW-1:0] H_X = XW'(H);
    localparam logic signed [XW-1:0] W_X = XW'(W);

    logic signed [XW-1:0] x;
    logic signed [XW-1:0] y;

    always_comb begin
        x = $signed(XW'(row)) * S_X - P_X + $signed(XW'(m));
        y = $signed(XW'(col)) * S_X - P_X + $signed(XW'(n));
        in_bounds = !x[XW-1] && (x < H_X) && !y[XW-1] && (y < W_X);
        // In bounds, x*W + y < H*W, so the narrow product cannot overflow.
        addr = in_bounds ? (x[AW-1:0] * AW'(W) + y[AW-1:0]) : '0;
    end

endmodule

// File: rtl/patch_streamer.sv
// Sweeps a KxK window over an HxW image in synchronous memory, one pixel per
// cycle, and hands each assembled patch downstream on a valid/ready stream.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | waiting for start
//   ST_FETCH | issuing one element read (or pad) per cycle, e = 0..K*K-1
//   ST_LAST  | capturing the final element returned by memory
//   ST_EMIT  | patch_valid high, holding patch until patch_ready
//   ST_DONE  | one-cycle done pulse after the last patch handshake
module patch_streamer
    import cnn_pkg::*;
#(
    parameter int H  = 5,
    parameter int W  = 5,
    parameter int K  = 3,
    parameter int S  = 1,
    parameter int P  = 1,
    parameter int DW = DW_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic [clog2_min1(H*W)-1:0] mem_addr,
    input  logic [DW-1:0]         mem_rdata,
    output logic                  patch_valid,
    input  logic                  patch_ready,
    output logic [K*K*DW-1:0]     patch_data,
    output logic [clog2_min1(conv_out_size(H, K, S, P))-1:0] patch_row,
    output logic [clog2_min1(conv_out_size(W, K, S, P))-1:0] patch_col
);

    localparam int OH = conv_out_size(H, K, S, P);
    localparam int OW = conv_out_size(W, K, S, P);
    localparam int AW = clog2_min1(H * W);
    localparam int RW = clog2_min1(OH);
    localparam int CW = clog2_min1(OW);
    localparam int KK = K * K;
    localparam int EW = clog2_min1(KK);
    localparam int KW = clog2_min1(K);

    localparam logic [EW-1:0] E_LAST   = EW'(KK - 1);
    localparam logic [KW-1:0] N_LAST   = KW'(K - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(OH - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(OW - 1);

    ps_state_t     state;
    logic [RW-1:0] row_q;
    logic [CW-1:0] col_q;
    logic [EW-1:0] e_q;
    logic [KW-1:0] m_q;
    logic [KW-1:0] n_q;
    logic          tag_valid;
    logic [EW-1:0] tag_e;
    logic          tag_pad;

    logic [AW-1:0] gen_addr;
    logic          gen_in_bounds;

    patch_addr_gen #(
        .H (H),
        .W (W),
        .K (K),
        .S (S),
        .P (P),
        .AW(AW),
        .RW(RW),
        .CW(CW),
        .KW(KW)
    ) u_addr_gen (
        .row      (row_q),
        .col      (col_q),
        .m        (m_q),
        .n        (n_q),
        .addr     (gen_addr),
        .in_bounds(gen_in_bounds)
    );

    assign mem_rd_en = (state == ST_FETCH) && gen_in_bounds;
    assign mem_addr  = mem_rd_en ? gen_addr : '0;
    assign patch_row = row_q;
    assign patch_col = col_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            e_q         <= '0;
            m_q         <= '0;
            n_q         <= '0;
            tag_valid   <= 1'b0;
            tag_e       <= '0;
            tag_pad     <= 1'b0;
            patch_data  <= '0;
            patch_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            // Memory data for the element tagged last cycle arrives now.
            if (tag_valid) begin
                patch_data[tag_e*DW +: DW] <= tag_pad ? '0 : mem_rdata;
            end
            tag_valid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        row_q      <= '0;
                        col_q      <= '0;
                        e_q        <= '0;
                        m_q        <= '0;
                        n_q        <= '0;
                        patch_data <= '0;
                        busy       <= 1'b1;
                        state      <= ST_FETCH;
                    end
                end

                ST_FETCH: begin
                    tag_valid <= 1'b1;
                    tag_e     <= e_q;
                    tag_pad   <= !gen_in_bounds;
                    if (e_q == E_LAST) begin
                        state <= ST_LAST;
                    end else begin
                        e_q <= e_q + EW'(1);
                        if (n_q == N_LAST) begin
                            n_q <= '0;
                            m_q <= m_q + KW'(1);
                        end else begin
                            n_q <= n_q + KW'(1);
                        end
                    end
                end

                ST_LAST: begin
                    patch_valid <= 1'b1;
                    state       <= ST_EMIT;
                end

                ST_EMIT: begin
                    if (patch_ready) begin
                        patch_valid <= 1'b0;
                        if (row_q == ROW_LAST && col_q == COL_LAST) begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            if (col_q == COL_LAST) begin
                                col_q <= '0;
                                row_q <= row_q + RW'(1);
                            end else begin
                                col_q <= col_q + CW'(1);
                            end
                            e_q        <= '0;
                            m_q        <= '0;
                            n_q        <= '0;
                            patch_data <= '0;
                            state      <= ST_FETCH;
                        end
                    end
                end

                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_patch_streamer.sv
// Randomized self-checking bench: two streamer configurations against a
// window/padding reference model computed directly from image coordinates.
module tb_patch_streamer;

    localparam int H  = 5;
    localparam int W  = 5;
    localparam int K  = 3;
    localparam int DW = 8;
    localparam int PW = K * K * DW;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [7:0] img [H*W];

    int n_cmp = 0;
    int n_bad = 0;

    // index 0: S=1,P=1 (5x5 outputs); index 1: S=2,P=0 (2x2 outputs)
    int s_of  [2] = '{1, 2};
    int p_of  [2] = '{1, 0};
    int oh_of [2] = '{5, 2};

    logic          start_s [2];
    logic          ready_s [2];
    logic          busy_s  [2];
    logic          done_s  [2];
    logic          rd_s    [2];
    logic          valid_s [2];
    logic [4:0]    addr_s  [2];
    logic [7:0]    rdata_s [2];
    logic [PW-1:0] data_s  [2];
    logic [2:0]    row1, col1;
    logic [0:0]    row2, col2;

    patch_streamer #(.H(H), .W(W), .K(K), .S(1), .P(1), .DW(DW)) u_dut_pad (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .busy(busy_s[0]), .done(done_s[0]),
        .mem_rd_en(rd_s[0]), .mem_addr(addr_s[0]), .mem_rdata(rdata_s[0]),
        .patch_valid(valid_s[0]), .patch_ready(ready_s[0]), .patch_data(data_s[0]),
        .patch_row(row1), .patch_col(col1)
    );

    patch_streamer #(.H(H), .W(W), .K(K), .S(2), .P(0), .DW(DW)) u_dut_str (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .busy(busy_s[1]), .done(done_s[1]),
        .mem_rd_en(rd_s[1]), .mem_addr(addr_s[1]), .mem_rdata(rdata_s[1]),
        .patch_valid(valid_s[1]), .patch_ready(ready_s[1]), .patch_data(data_s[1]),
        .patch_row(row2), .patch_col(col2)
    );

    always @(posedge clk) begin
        if (rd_s[0]) rdata_s[0] <= (addr_s[0] < 5'd25) ? img[addr_s[0]] : 8'hEE;
        if (rd_s[1]) rdata_s[1] <= (addr_s[1] < 5'd25) ? img[addr_s[1]] : 8'hEE;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int cur_row(input int k);
        return (k == 0) ? int'(row1) : int'(row2);
    endfunction

    function automatic int cur_col(input int k);
        return (k == 0) ? int'(col1) : int'(col2);
    endfunction

    // Reference: pixel at window offset (m,n) of output (i,j), zero off-image.
    function automatic logic [PW-1:0] ref_patch(input int k, input int i, input int j);
        logic [PW-1:0] r;
        r = '0;
        for (int m = 0; m < K; m++) begin
            for (int n = 0; n < K; n++) begin
                int x, y;
                x = i * s_of[k] - p_of[k] + m;
                y = j * s_of[k] - p_of[k] + n;
                if (x >= 0 && x < H && y >= 0 && y < W)
                    r[(m*K+n)*DW +: DW] = img[x*W+y];
            end
        end
        return r;
    endfunction

    function automatic int inb_count(input int k, input int i, input int j);
        int c;
        c = 0;
        for (int m = 0; m < K; m++) begin
            for (int n = 0; n < K; n++) begin
                int x, y;
                x = i * s_of[k] - p_of[k] + m;
                y = j * s_of[k] - p_of[k] + n;
                if (x >= 0 && x < H && y >= 0 && y < W) c++;
            end
        end
        return c;
    endfunction

    int            exp_i  [2];
    int            exp_j  [2];
    int            n_pat  [2];
    int            n_done [2];
    int            rd_cnt [2];
    bit            last_hs[2];
    logic [PW-1:0] cap    [2][5][5];

    task automatic mon_clear(input int k);
        exp_i[k] = 0; exp_j[k] = 0; n_pat[k] = 0; n_done[k] = 0; rd_cnt[k] = 0; last_hs[k] = 0;
    endtask

    task automatic mon_step(input int k);
        if (rd_s[k]) begin
            rd_cnt[k]++;
            check("rd_addr_range", addr_s[k] < 5'd25, 1'b1);
            check("rd_while_valid", valid_s[k], 1'b0);
        end
        if (valid_s[k]) begin
            check("patch_data", data_s[k], ref_patch(k, exp_i[k], exp_j[k]));
            check("patch_row", cur_row(k), exp_i[k]);
            check("patch_col", cur_col(k), exp_j[k]);
            if (ready_s[k]) begin
                check("rd_count", rd_cnt[k], inb_count(k, exp_i[k], exp_j[k]));
                rd_cnt[k] = 0;
                if (exp_i[k] < 5 && exp_j[k] < 5) cap[k][exp_i[k]][exp_j[k]] = data_s[k];
                n_pat[k]++;
                last_hs[k] = (exp_i[k] == oh_of[k] - 1) && (exp_j[k] == oh_of[k] - 1);
                if (exp_j[k] == oh_of[k] - 1) begin
                    exp_j[k] = 0;
                    exp_i[k]++;
                end else begin
                    exp_j[k]++;
                end
            end
        end
        if (done_s[k]) begin
            n_done[k]++;
            check("done_after_last", last_hs[k], 1'b1);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon_step(0);
            mon_step(1);
        end
    end

    // rmode: 0 ready=1, 1 random, 2 stall 10 cycles on patch (0,1)
    // smode: 0 single pulse, 1 random re-pulses while busy, 2 held until done
    task automatic sweep(input int k, input int rmode, input int smode,
                         output int first_valid, output int first_rd);
        int cyc, stall_n;
        bit seen;
        mon_clear(k);
        first_valid = -1;
        first_rd    = -1;
        stall_n     = 0;
        seen        = 0;
        @(posedge clk); #1;
        start_s[k] = 1'b1;
        ready_s[k] = 1'b1;
        cyc = 0;
        while (!seen && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            if (valid_s[k] && first_valid < 0) first_valid = cyc;
            if (rd_s[k] && first_rd < 0) first_rd = cyc;
            case (smode)
                1:       start_s[k] = busy_s[k] ? 1'($urandom_range(0, 1)) : 1'b0;
                2:       start_s[k] = 1'b1;
                default: start_s[k] = 1'b0;
            endcase
            case (rmode)
                1: ready_s[k] = 1'($urandom_range(0, 1));
                2: begin
                    if (valid_s[k] && cur_row(k) == 0 && cur_col(k) == 1 && stall_n < 10) begin
                        ready_s[k] = 1'b0;
                        stall_n++;
                    end else begin
                        ready_s[k] = 1'b1;
                    end
                end
                default: ready_s[k] = 1'b1;
            endcase
            if (done_s[k]) begin
                seen = 1;
                start_s[k] = 1'b0;
            end
        end
        check("sweep_timeout", seen, 1'b1);
        start_s[k] = 1'b0;
        ready_s[k] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_busy", busy_s[k], 1'b0);
        check("n_patches", n_pat[k], oh_of[k] * oh_of[k]);
        check("n_done", n_done[k], 1);
        if (rmode == 2) check("stall_cycles", stall_n, 10);
    endtask

    task automatic fill_ramp();
        for (int a = 0; a < H*W; a++) img[a] = 8'(a + 1);
    endtask

    task automatic fill_random();
        for (int a = 0; a < H*W; a++) img[a] = 8'($urandom_range(0, 255));
    endtask

    task automatic check_quiet(input string tag, input int k);
        check({tag, "_busy"},  busy_s[k],  1'b0);
        check({tag, "_valid"}, valid_s[k], 1'b0);
        check({tag, "_done"},  done_s[k],  1'b0);
        check({tag, "_data"},  data_s[k],  '0);
        check({tag, "_row"},   cur_row(k), 0);
        check({tag, "_col"},   cur_col(k), 0);
    endtask

    logic [PW-1:0] exp_p00, exp_p22, exp_p01, exp_s11;
    int fv, fr;
    bit found;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_p00 = {8'd7, 8'd6, 8'd0, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
        exp_p22 = {8'd19, 8'd18, 8'd17, 8'd14, 8'd13, 8'd12, 8'd9, 8'd8, 8'd7};
        exp_p01 = {8'd8, 8'd7, 8'd6, 8'd3, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0};
        exp_s11 = {8'd25, 8'd24, 8'd23, 8'd20, 8'd19, 8'd18, 8'd15, 8'd14, 8'd13};
        start_s = '{1'b0, 1'b0};
        ready_s = '{1'b0, 1'b0};
        rst_n   = 1'b0;
        fill_ramp();
        mon_clear(0);
        mon_clear(1);
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset0", 0);
        check_quiet("reset1", 1);
        check("reset_rd0", rd_s[0], 1'b0);
        check("reset_rd1", rd_s[1], 1'b0);
        rst_n = 1'b1;

        // basic padded sweep and start-to-valid latency
        sweep(0, 0, 0, fv, fr);
        check("first_valid_cycle", fv, 11);
        check("p00", cap[0][0][0], exp_p00);
        check("p22", cap[0][2][2], exp_p22);

        // stride 2, no padding: first read lands in cycle 1
        sweep(1, 0, 0, fv, fr);
        check("stride_first_rd", fr, 1);
        check("stride_first_valid", fv, 11);
        check("s11", cap[1][1][1], exp_s11);

        // backpressure on (0,1) with start re-pulsed while busy
        sweep(0, 2, 1, fv, fr);
        check("p01", cap[0][0][1], exp_p01);

        // start held high through the last handshake
        sweep(0, 0, 2, fv, fr);
        sweep(1, 0, 2, fv, fr);

        for (int r = 0; r < 3; r++) begin
            fill_random();
            sweep(0, 1, 1, fv, fr);
            sweep(1, 1, 1, fv, fr);
        end

        // reset in the middle of fetching patch (1,3)
        fill_ramp();
        mon_clear(0);
        @(posedge clk); #1;
        start_s[0] = 1'b1;
        ready_s[0] = 1'b1;
        found = 0;
        for (int c = 0; c < 500 && !found; c++) begin
            @(posedge clk); #1;
            start_s[0] = 1'b0;
            if (busy_s[0] && !valid_s[0] && cur_row(0) == 1 && cur_col(0) == 3) found = 1;
        end
        check("reach_fetch_13", found, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_quiet("midreset", 0);
        rst_n = 1'b1;
        ready_s[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("midreset_no_done", done_s[0], 1'b0);
        check("midreset_idle", busy_s[0], 1'b0);
        sweep(0, 0, 0, fv, fr);
        check("restart_first_valid", fv, 11);
        check("restart_p00", cap[0][0][0], exp_p00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
